uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

- UART transmitter for the RS232 path: accepts bytes from on-chip logic over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte as 8N1 frames on `tx` (1 start bit, 8 data bits LSB first, 1 stop bit) at a parameterized baud rate, default 9600 Bd from the 50 MHz board clock.
- Is the transmit-side counterpart of the RS232 receiver and drives the same serial line format that receiver expects.

## Interface

Parameters:
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 9600, serial bit rate.
- `FIFO_DEPTH`, 16, byte buffer depth; power of two, minimum 2.
- Derived `BAUD_CNT_MAX` = CLK_FREQ/BAUD, integer division. Default is 5208 cycles per bit.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO not full; a byte is accepted on any edge where `tx_valid && tx_ready`.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  high while a frame is on the line (START, DATA or STOP state).
- `fifo_count`  out  log2(FIFO_DEPTH)+1  number of bytes buffered, not counting the byte being shifted.

## Operation

- FIFO:
  - Circular buffer with write/read pointers and an occupancy count.
  - Push when `tx_valid && tx_ready`. `tx_ready = (fifo_count != FIFO_DEPTH)`.
  - When full, a push is refused even if a pop happens on the same edge.
  - Push and pop on the same edge leave `fifo_count` unchanged.
  - A pop never happens when the FIFO is empty.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - `tx` = 1.
    - If FIFO non-empty: pop the head into the 8-bit shift register, clear the baud counter and bit index, go to START.
  - START:
    - `tx` = 0 for BAUD_CNT_MAX cycles, then go to DATA.
  - DATA:
    - `tx` = shift_reg[0] for BAUD_CNT_MAX cycles per bit.
    - At the end of each bit: shift right, increment the bit index.
    - After bit index 7, go to STOP.
  - STOP:
    - `tx` = 1 for BAUD_CNT_MAX cycles.
    - On the last cycle, if the FIFO is non-empty: pop, go directly to START (no idle gap between frames).
    - Otherwise go to IDLE.
- Baud counter:
  - Counts 0..BAUD_CNT_MAX-1; the bit ends when it reaches BAUD_CNT_MAX-1.
  - Resets to 0 on every state change.
  - Width is sufficient for BAUD_CNT_MAX-1; 13 bits at the defaults.
- `busy` = (state != IDLE).
- `tx` is driven from a register decoded from the next state/bit, so no glitches.

## Timing

- Reset (edge with `rst_n` = 0) sets:
  - `tx` = 1, `busy` = 0, `fifo_count` = 0, `tx_ready` = 1.
  - FSM = IDLE, pointers = 0, shift register = 0.
- Reset mid-frame aborts the frame:
  - `tx` is high after that edge and buffered bytes are discarded.
  - Nothing resumes after release until a new byte is pushed.
- Latency into an empty, idle block:
  - Byte accepted at edge N.
  - `fifo_count` = 1 after edge N.
  - Pop at edge N+1 (`fifo_count` back to 0, `busy` = 1).
  - `tx` falls after edge N+1.
- Frame length is exactly 10*BAUD_CNT_MAX cycles (52080 at the defaults).
- Back-to-back frames are separated by 0 idle cycles.
- `tx_ready` deasserts on the edge the count reaches FIFO_DEPTH. It reasserts on the edge after a pop from full.
- `tx_data` is sampled only on an accepting edge; it may change freely otherwise.

## Test plan

- Single byte:
  - Stimulus: after reset, push 0x55.
  - Required: `tx` low 5208 cycles, then bits 1,0,1,0,1,0,1,0 at 5208 cycles each, then stop high 5208 cycles.
  - Required: `busy` is high for exactly 52080 cycles.
  - Required: `fifo_count` goes 1→0 on the next edge.
- Back-to-back:
  - Stimulus: push 0xA5, 0x3C, 0xFF in consecutive cycles.
  - Required: three frames with the next start bit immediately after each stop bit, total `busy` = 156240 cycles.
  - Required: decoded bytes are 0xA5, 0x3C, 0xFF.
- Full FIFO:
  - Stimulus: hold `tx_valid` for 20 consecutive cycles from idle.
  - Required: 17 bytes accepted (1 popped plus 16 buffered), `tx_ready` low with `fifo_count` = 16, bytes 18–20 held.
  - Required: `tx_ready` rises one edge after the first stop-bit-end pop; the output sequence matches push order.
- Reset mid-frame:
  - Stimulus: push 0x00 and 0x81, then assert `rst_n` = 0 for 1 cycle during a data bit.
  - Required: `tx` = 1, `busy` = 0, `fifo_count` = 0 after that edge; line stays high afterward.
- Loopback:
  - Stimulus: connect `tx` to the RS232 receiver's `rx` and push 8 random bytes.
  - Required: the received bytes equal the pushed bytes, in order, with no framing errors.
- Parameter check:
  - Stimulus: BAUD = 115200.
  - Required: bit width is 434 cycles and a frame is 4340 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a circular byte FIFO; first start bit is driven one edge after a byte lands in an idle block.
// tx_ready drops when the FIFO holds FIFO_DEPTH bytes; frames leave back-to-back while bytes remain buffered.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD;
    localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               tx_q, tx_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic               push;
    logic               pop;
    logic               baud_end;
    logic               not_empty;

    always_comb begin
        push       = tx_valid && (count_q != FULL_CNT);
        not_empty  = (count_q != '0);
        baud_end   = (baud_cnt_q == BAUD_LAST);

        state_d    = state_q;
        baud_cnt_d = baud_end ? '0 : baud_cnt_q + CNT_W'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                if (not_empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_idx_d = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    // Reload straight into START so consecutive frames have no idle gap.
                    if (not_empty) begin
                        pop       = 1'b1;
                        shift_d   = mem_q[rd_ptr_q];
                        bit_idx_d = '0;
                        state_d   = ST_START;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        // Line level follows the state being entered so tx changes on the same edge as the FSM.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    assign tx_ready   = (count_q != FULL_CNT);
    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE);
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table of single frames, multi-cycle corner sequences, and a line-decoding scoreboard.
module tb_uart_tx_fifo;

    localparam int M  = 10;     // cycles per bit for the main instance (1000 Hz / 100 Bd)
    localparam int FM = 434;    // cycles per bit for 50 MHz / 115200 Bd

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;

    logic [7:0] tx_data_f;
    logic       tx_valid_f;
    logic       tx_ready_f;
    logic       tx_f;
    logic       busy_f;
    logic [4:0] fifo_count_f;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(16)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(115200), .FIFO_DEPTH(16)) u_fast (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data_f),
        .tx_valid   (tx_valid_f),
        .tx_ready   (tx_ready_f),
        .tx         (tx_f),
        .busy       (busy_f),
        .fifo_count (fifo_count_f)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 = start, bits 8:1 = data LSB first, bit 9 = stop
    } vec_t;

    vec_t       vecs [5];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] sb [$];
    int         rst_epoch = 0;
    int         frames = 0;
    int         busy_cnt = 0;
    int         busy_fall = 0;
    logic       busy_prev = 1'b0;
    logic       last_acc = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive at a falling edge, let the rising edge act, return at the next falling edge.
    task automatic cyc(input logic v, input logic [7:0] d);
        tx_valid = v;
        tx_data  = d;
        last_acc = v && (tx_ready === 1'b1);
        if (last_acc) sb.push_back(d);
        @(negedge clk);
        if (busy === 1'b1) busy_cnt++;
        if (busy_prev === 1'b1 && busy !== 1'b1) busy_fall++;
        busy_prev = busy;
    endtask

    task automatic drain(input string name, input int bound);
        int k;
        k = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && k < bound) begin
            cyc(1'b0, 8'h00);
            k++;
        end
        check(name, (k < bound), 1);
    endtask

    // Line decoder: every bit period must be constant, start low, stop high; bytes popped from the scoreboard.
    initial begin : monitor
        logic       first;
        logic       fmt_ok;
        logic [7:0] rb;
        logic [7:0] exp_b;
        int         ep;
        forever begin
            @(negedge clk);
            if (tx !== 1'b0) continue;
            ep     = rst_epoch;
            fmt_ok = 1'b1;
            rb     = 8'h00;
            first  = 1'b0;
            for (int s = 0; s < 10; s++) begin
                for (int j = 0; j < M; j++) begin
                    if (s != 0 || j != 0) @(negedge clk);
                    if (j == 0) first = tx;
                    else if (tx !== first) fmt_ok = 1'b0;
                end
                if (s == 0 && first !== 1'b0) fmt_ok = 1'b0;
                if (s == 9 && first !== 1'b1) fmt_ok = 1'b0;
                if (s >= 1 && s <= 8) rb[s-1] = first;
            end
            if (ep == rst_epoch) begin
                frames++;
                check("frame_fmt", fmt_ok, 1);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: got 0x%0h, want none", rb);
                end else begin
                    exp_b = sb.pop_front();
                    check("rx_byte", rb, exp_b);
                end
            end
        end
    end

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   idx;
        int   acc_cnt;
        int   k;
        logic line_ok;
        int   fb;
        int   low;
        logic seen_low;
        logic done_low;
        logic [7:0] d;

        vecs[0] = '{data: 8'h55, frame: 10'b1010101010};
        vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
        vecs[3] = '{data: 8'h81, frame: 10'b1100000010};
        vecs[4] = '{data: 8'h3C, frame: 10'b1001111000};

        rst_n      = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        tx_valid_f = 1'b0;
        tx_data_f  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_fast_tx", tx_f, 1);
        rst_n = 1'b1;
        cyc(1'b0, 8'h00);

        // Single frames from idle, checked at each bit centre.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, vecs[i].data);
            check($sformatf("v%0d_acc_count", i), fifo_count, 1);
            check($sformatf("v%0d_acc_busy", i), busy, 0);
            cyc(1'b0, 8'h00);
            check($sformatf("v%0d_pop_count", i), fifo_count, 0);
            check($sformatf("v%0d_pop_busy", i), busy, 1);
            idx = 0;
            for (int s = 0; s < 10; s++) begin
                while (idx < s * M + M / 2) begin
                    cyc(1'b0, 8'h00);
                    idx++;
                end
                check($sformatf("v%0d_bit%0d", i, s), tx, vecs[i].frame[s]);
            end
            while (idx < 10 * M - 1) begin
                cyc(1'b0, 8'h00);
                idx++;
            end
            check($sformatf("v%0d_busy_last", i), busy, 1);
            cyc(1'b0, 8'h00);
            check($sformatf("v%0d_busy_end", i), busy, 0);
            check($sformatf("v%0d_tx_end", i), tx, 1);
            cyc(1'b0, 8'h00);
            cyc(1'b0, 8'h00);
        end

        // Back-to-back: busy must stay high continuously across three frames.
        busy_cnt  = 0;
        busy_fall = 0;
        busy_prev = busy;
        cyc(1'b1, 8'hA5);
        cyc(1'b1, 8'h3C);
        cyc(1'b1, 8'hFF);
        drain("b2b_drain", 600);
        check("b2b_busy_cycles", busy_cnt, 30 * M);
        check("b2b_busy_falls", busy_fall, 1);

        // Full FIFO: 20 cycles of valid from idle.
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'h10 + 8'(i));
            if (last_acc) acc_cnt++;
        end
        check("full_accepted", acc_cnt, 17);
        check("full_ready", tx_ready, 0);
        check("full_count", fifo_count, 16);
        k = 0;
        while (tx_ready !== 1'b1 && k < 500) begin
            cyc(1'b0, 8'h00);
            k++;
        end
        check("full_ready_rise_cyc", k, 10 * M - 18);
        check("full_count_after_pop", fifo_count, 15);
        drain("full_drain", 2500);

        // Reset during a data bit.
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'h81);
        repeat (2 * M + 3) cyc(1'b0, 8'h00);
        check("mid_busy_before", busy, 1);
        rst_epoch++;
        rst_n = 1'b0;
        cyc(1'b0, 8'h00);
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", fifo_count, 0);
        rst_n = 1'b1;
        sb.delete();
        line_ok = 1'b1;
        for (int i = 0; i < 12 * M; i++) begin
            cyc(1'b0, 8'h00);
            if (tx !== 1'b1 || busy !== 1'b0) line_ok = 1'b0;
        end
        check("mid_line_idle", line_ok, 1);

        // Loopback through the decoder with random bytes and gaps.
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 150)) cyc(1'b0, 8'h00);
            cyc(1'b1, d);
            check($sformatf("lb_acc%0d", i), last_acc, 1);
        end
        drain("lb_drain", 3000);

        // 115200 Bd at 50 MHz.
        tx_data_f  = 8'hA5;
        tx_valid_f = 1'b1;
        @(negedge clk);
        tx_valid_f = 1'b0;
        fb       = 0;
        low      = 0;
        seen_low = 1'b0;
        done_low = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (busy_f === 1'b1) fb++;
            if (tx_f === 1'b0 && !done_low) begin
                low++;
                seen_low = 1'b1;
            end else if (seen_low) begin
                done_low = 1'b1;
            end
        end
        check("fast_bit_cycles", low, FM);
        check("fast_frame_cycles", fb, 10 * FM);

        check("frames_seen", frames, 33);
        check("sb_left", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
